// File: rtl/key_event_arbiter.sv
// key_event_arbiter: turns 2-bit key decoder code onsets into single events,
// keeps one pending event per key, picks among pending keys round-robin and
// queues the winner into a show-ahead FIFO with a valid/ready consumer side.
module key_event_arbiter #(
    parameter int NUM_KEYS   = 4,
    parameter int ID_W       = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_100,
    input  logic                          rst,
    input  logic [2*NUM_KEYS-1:0]         key_code,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [ID_W-1:0]               evt_id,
    output logic                          evt_long,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic [7:0]                    drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [2*NUM_KEYS-1:0] prev_q;
    logic [NUM_KEYS-1:0]   onset;
    logic [NUM_KEYS-1:0]   pend_q, pend_d;
    logic [NUM_KEYS-1:0]   kind_q, kind_d;
    logic [ID_W-1:0]       rr_q, rr_d;
    logic [ID_W:0]         mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [7:0]            drop_q, drop_d;

    logic                  grant_vld;
    logic [ID_W-1:0]       grant_idx;
    logic                  grant_kind;
    logic                  hi_found, lo_found;
    logic [ID_W-1:0]       hi_idx, lo_idx;
    logic                  hi_kind, lo_kind;
    logic [4:0]            ndrop;
    logic [8:0]            drop_sum;
    logic                  push, pop;

    // Previous code follows the input every cycle, including during reset,
    // so a code held across reset never looks like an onset.
    always_ff @(posedge clk_100) begin
        prev_q <= key_code;
    end

    // Onset: previous code idle (bit0 clear, so 10 counts as idle) and
    // current code active (01 or 11).
    always_comb begin
        onset = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            onset[i] = ~prev_q[2*i] & key_code[2*i];
        end
    end

    // Round-robin search: first pending channel at or above rr_q, else the
    // first pending channel below it (wrap-around).
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        hi_kind  = 1'b0;
        lo_kind  = 1'b0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (!hi_found && pend_q[i] && (i >= 32'(rr_q))) begin
                hi_found = 1'b1;
                hi_idx   = ID_W'(i);
                hi_kind  = kind_q[i];
            end
            if (!lo_found && pend_q[i]) begin
                lo_found = 1'b1;
                lo_idx   = ID_W'(i);
                lo_kind  = kind_q[i];
            end
        end
        grant_vld  = (hi_found || lo_found) && (count_q < CW'(FIFO_DEPTH));
        grant_idx  = hi_found ? hi_idx : lo_idx;
        grant_kind = hi_found ? hi_kind : lo_kind;
        rr_d       = rr_q;
        if (grant_vld) begin
            rr_d = (grant_idx == ID_W'(NUM_KEYS - 1)) ? '0 : grant_idx + ID_W'(1);
        end
    end

    // Pending store and drop accounting; a new onset wins over the grant clear,
    // and re-arming the channel being granted this cycle is not a drop.
    always_comb begin
        pend_d = pend_q;
        kind_d = kind_q;
        ndrop  = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (grant_vld && (grant_idx == ID_W'(i))) begin
                pend_d[i] = 1'b0;
            end
            if (onset[i]) begin
                pend_d[i] = 1'b1;
                kind_d[i] = key_code[2*i+1];
                if (pend_q[i] && !(grant_vld && (grant_idx == ID_W'(i)))) begin
                    ndrop = ndrop + 5'd1;
                end
            end
        end
        drop_sum = {1'b0, drop_q} + {4'b0, ndrop};
        drop_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
        ovf_d    = (ndrop != '0) ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end

    // FIFO pointer and occupancy update.
    always_comb begin
        push    = grant_vld;
        pop     = (count_q != '0) && evt_ready;
        wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // State registers; reset discards pending and queued events.
    always_ff @(posedge clk_100) begin
        if (rst) begin
            pend_q  <= '0;
            kind_q  <= '0;
            rr_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            pend_q  <= pend_d;
            kind_q  <= kind_d;
            rr_q    <= rr_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    // FIFO storage; contents are only observable through count_q.
    always_ff @(posedge clk_100) begin
        if (!rst && push) begin
            mem_q[wptr_q] <= {grant_idx, grant_kind};
        end
    end

    // Show-ahead head; zeros when empty.
    always_comb begin
        evt_valid = (count_q != '0);
        evt_id    = evt_valid ? mem_q[rptr_q][ID_W:1] : '0;
        evt_long  = evt_valid ? mem_q[rptr_q][0] : 1'b0;
    end

    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign drop_cnt   = drop_q;

endmodule
